// File: rtl/cp0_int_timer.sv
// Interrupt front end for CP0: pin synchronisers, Count/Compare timer and register snoop.
// Optional build macro INT_DEBOUNCE_EN adds a per-pin stability filter after the synchroniser.
module cp0_int_timer #(
  parameter int SYNC_STAGES     = 2,
  parameter int TIMER_IRQ_BIT   = 5,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_pin,
  input  logic        write_en,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_addr,
  output logic [31:0] read_data,
  output logic [5:0]  int_out,
  output logic        timer_irq
);

  localparam logic [4:0] COUNT_ADDR   = 5'd9;
  localparam logic [4:0] COMPARE_ADDR = 5'd11;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMER_IRQ_BIT < 0 || TIMER_IRQ_BIT > 5) begin : g_bad_bit
    $error("TIMER_IRQ_BIT must be in 0..5");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [5:0]  sync_q [SYNC_STAGES];
  logic [5:0]  pins_w;
  logic [31:0] count_q, count_d, count_inc;
  logic [31:0] compare_q, compare_d;
  logic [31:0] read_q, read_d;
  logic [5:0]  int_out_q, int_out_d;
  logic        toggle_q;
  logic        irq_q, irq_d;
  logic        count_wr, compare_wr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= int_pin;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef INT_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [5:0]     filt_q;
  logic [DBW-1:0] dbc_q [6];

  // A pin flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      filt_q <= '0;
      for (int p = 0; p < 6; p++) dbc_q[p] <= '0;
    end else begin
      for (int p = 0; p < 6; p++) begin
        if (sync_q[SYNC_STAGES-1][p] != filt_q[p]) begin
          if (dbc_q[p] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            filt_q[p] <= ~filt_q[p];
            dbc_q[p]  <= '0;
          end else begin
            dbc_q[p]  <= dbc_q[p] + 1'b1;
          end
        end else begin
          dbc_q[p] <= '0;
        end
      end
    end
  end

  assign pins_w = filt_q;
`else
  assign pins_w = sync_q[SYNC_STAGES-1];
`endif

  assign count_wr   = write_en && (write_addr == COUNT_ADDR);
  assign compare_wr = write_en && (write_addr == COMPARE_ADDR);
  assign count_inc  = count_q + 32'd1;

  // A Count write replaces the increment; a Compare write overrides any match on the same edge.
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    irq_d     = irq_q;
    if (count_wr) begin
      count_d = write_data;
    end else if (toggle_q) begin
      count_d = count_inc;
      if (count_inc == compare_q) irq_d = 1'b1;
    end
    if (compare_wr) begin
      compare_d = write_data;
      irq_d     = 1'b0;
    end

    read_d = '0;
    if (read_addr == COUNT_ADDR)        read_d = count_q;
    else if (read_addr == COMPARE_ADDR) read_d = compare_q;

    int_out_d = pins_w;
    int_out_d[TIMER_IRQ_BIT] = pins_w[TIMER_IRQ_BIT] | irq_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= '0;
      compare_q <= '0;
      toggle_q  <= 1'b0;
      irq_q     <= 1'b0;
      read_q    <= '0;
      int_out_q <= '0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      toggle_q  <= ~toggle_q;
      irq_q     <= irq_d;
      read_q    <= read_d;
      int_out_q <= int_out_d;
    end
  end

  assign read_data = read_q;
  assign int_out   = int_out_q;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_cp0_int_timer.sv
// Directed bench for cp0_int_timer: vector table for sync/read behaviour, hand sequences for timer corners.
module tb_cp0_int_timer;

  logic        clk;
  logic        rst;
  logic [5:0]  int_pin;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr;
  logic [31:0] read_data;
  logic [5:0]  int_out;
  logic        timer_irq;

  int checks   = 0;
  int failures = 0;

  cp0_int_timer dut (
    .clk        (clk),
    .rst        (rst),
    .int_pin    (int_pin),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .int_out    (int_out),
    .timer_irq  (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  pin;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [5:0]  exp_int;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra);
    write_en   = we;
    write_addr = wa;
    write_data = wd;
    read_addr  = ra;
    @(posedge clk);
    #1;
    write_en   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] exp_i;

    vecs[0]  = '{6'h01, 1'b0, 5'd0,  32'h0,    5'd9,  6'h00, 32'd0};
    vecs[1]  = '{6'h01, 1'b0, 5'd0,  32'h0,    5'd9,  6'h00, 32'd0};
    vecs[2]  = '{6'h01, 1'b0, 5'd0,  32'h0,    5'd9,  6'h01, 32'd1};
    vecs[3]  = '{6'h00, 1'b0, 5'd0,  32'h0,    5'd9,  6'h01, 32'd1};
    vecs[4]  = '{6'h00, 1'b0, 5'd0,  32'h0,    5'd11, 6'h01, 32'd0};
    vecs[5]  = '{6'h00, 1'b0, 5'd0,  32'h0,    5'd12, 6'h00, 32'd0};
    vecs[6]  = '{6'h00, 1'b1, 5'd11, 32'h1000, 5'd11, 6'h00, 32'd0};
    vecs[7]  = '{6'h00, 1'b0, 5'd0,  32'h0,    5'd11, 6'h00, 32'h1000};
    vecs[8]  = '{6'h00, 1'b1, 5'd10, 32'hDEAD, 5'd9,  6'h00, 32'd4};
    vecs[9]  = '{6'h00, 1'b0, 5'd0,  32'h0,    5'd9,  6'h00, 32'd4};
    vecs[10] = '{6'h00, 1'b0, 5'd0,  32'h0,    5'd11, 6'h00, 32'h1000};

    rst = 1'b0; int_pin = 6'h3F;
    write_en = 1'b0; write_addr = '0; write_data = '0; read_addr = 5'd9;
    repeat (3) cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("reset_int_out", {26'h0, int_out}, 32'h0);
    chk("reset_read", read_data, 32'h0);
    chk("reset_irq", {31'h0, timer_irq}, 32'h0);

    rst = 1'b1;
    for (int i = 0; i < 11; i++) begin
      int_pin = vecs[i].pin;
      cyc(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra);
`ifdef INT_DEBOUNCE_EN
      exp_i = 6'h00;
`else
      exp_i = vecs[i].exp_int;
`endif
      chk($sformatf("vec%0d_int_out", i), {26'h0, int_out}, {26'h0, exp_i});
      chk($sformatf("vec%0d_read", i), read_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'h0, timer_irq}, 32'h0);
    end

    // Mid-run reset, then timer match at Compare=10
    rst = 1'b0; int_pin = 6'h3F;
    repeat (2) cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("rst2_int_out", {26'h0, int_out}, 32'h0);
    chk("rst2_read", read_data, 32'h0);
    rst = 1'b1; int_pin = 6'h00;
    cyc(1'b1, 5'd11, 32'd10, 5'd9);
    chk("t_f1_read", read_data, 32'd0);
    repeat (18) cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("t_f19_irq", {31'h0, timer_irq}, 32'h0);
    chk("t_f19_read", read_data, 32'd9);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("t_f20_irq", {31'h0, timer_irq}, 32'h1);
    chk("t_f20_int_out", {26'h0, int_out}, 32'h0);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("t_f21_int_out", {26'h0, int_out}, 32'h20);
    chk("t_f21_read", read_data, 32'd10);
    cyc(1'b1, 5'd11, 32'd50, 5'd9);
    chk("t_f22_irq_clr", {31'h0, timer_irq}, 32'h0);
    chk("t_f22_int_out", {26'h0, int_out}, 32'h20);

    // Compare write on a match edge
    cyc(1'b1, 5'd9, 32'd48, 5'd9);
    chk("c_f23_int_out", {26'h0, int_out}, 32'h0);
    chk("c_f23_read", read_data, 32'd11);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("c_f24_read", read_data, 32'd48);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("c_f25_read", read_data, 32'd49);
    cyc(1'b1, 5'd11, 32'd100, 5'd9);
    chk("c_f26_irq", {31'h0, timer_irq}, 32'h0);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("c_f27_count", read_data, 32'd50);
    chk("c_f27_irq", {31'h0, timer_irq}, 32'h0);

    // Wrap to zero with Compare=0
    cyc(1'b1, 5'd11, 32'd0, 5'd11);
    chk("w_f28_old_compare", read_data, 32'd100);
    cyc(1'b1, 5'd9, 32'hFFFF_FFFE, 5'd11);
    chk("w_f29_new_compare", read_data, 32'd0);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("w_f30_read", read_data, 32'hFFFF_FFFE);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("w_f31_read", read_data, 32'hFFFF_FFFF);
    chk("w_f31_irq", {31'h0, timer_irq}, 32'h0);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("w_f32_irq", {31'h0, timer_irq}, 32'h1);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("w_f33_wrapped", read_data, 32'd0);

    // Count write on an increment edge suppresses the increment
    cyc(1'b1, 5'd9, 32'h55, 5'd9);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("cw_f35_read", read_data, 32'h55);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    cyc(1'b1, 5'd11, 32'h60, 5'd9);
    chk("cw_f37_read", read_data, 32'h56);
    chk("cw_f37_irq_clr", {31'h0, timer_irq}, 32'h0);
    cyc(1'b1, 5'd9, 32'h5E, 5'd9);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("cw_f39_read", read_data, 32'h5E);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("cw_f41_read", read_data, 32'h5F);
    cyc(1'b1, 5'd9, 32'h200, 5'd9);
    chk("cw_f42_irq", {31'h0, timer_irq}, 32'h0);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("cw_f43_read", read_data, 32'h200);
    chk("cw_f43_irq", {31'h0, timer_irq}, 32'h0);

    // Pending flag dropped by reset
    cyc(1'b1, 5'd11, 32'h202, 5'd9);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("r_f45_read", read_data, 32'h201);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("r_f46_irq", {31'h0, timer_irq}, 32'h1);
    rst = 1'b0; int_pin = 6'h3F;
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("r_f47_irq", {31'h0, timer_irq}, 32'h0);
    chk("r_f47_int_out", {26'h0, int_out}, 32'h0);
    chk("r_f47_read", read_data, 32'h0);
    rst = 1'b1; int_pin = 6'h00;
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("r_f48_int_out", {26'h0, int_out}, 32'h0);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("r_f49_int_out", {26'h0, int_out}, 32'h0);
    chk("r_f49_read", read_data, 32'h0);

`ifdef INT_DEBOUNCE_EN
    // Six-cycle pulse passes the filter
    int_pin = 6'h01;
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 5'd0, 32'h0, 5'd9);
      chk($sformatf("deb_p%0d_int_out", i), {26'h0, int_out}, 32'h0);
    end
    int_pin = 6'h00;
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("deb_p7_int_out", {26'h0, int_out}, 32'h01);
    repeat (5) cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("deb_p12_int_out", {26'h0, int_out}, 32'h01);
    cyc(1'b0, 5'd0, 32'h0, 5'd9);
    chk("deb_p13_int_out", {26'h0, int_out}, 32'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
